// File: rtl/rand_history_viewer_pkg.sv
// Shared constants and state encoding for the random-number generator and its history viewer.
package rand_pkg;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 16;
    localparam int IDX_W  = 4;
    localparam int CNT_W  = IDX_W + 1;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_LIVE,
        S_BROWSE
    } state_e;

endpackage

// File: rtl/rand_history_viewer_key_edge_detect.sv
// Rising-edge detector for a debounced key level; o_rise is high in the cycle the level first goes high.
module key_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    output logic o_rise
);

    logic level_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= i_level;
        end
    end

    assign o_rise = i_level & ~level_q;

endmodule

// File: rtl/rand_history_viewer.sv
// Circular history of settled random values with prev/next browsing for the seven-segment display path.
module rand_history_viewer
    import rand_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_prev,
    input  logic              i_next,
    output logic [DATA_W-1:0] o_view_data,
    output logic [IDX_W-1:0]  o_view_idx,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_browsing
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   view_idx_q, view_idx_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic               prev_rise, next_rise;
    logic               prev_evt, next_evt;
    logic [IDX_W-1:0]   rd_addr;

    key_edge_detect u_prev_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_level (i_prev),
        .o_rise  (prev_rise)
    );

    key_edge_detect u_next_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_level (i_next),
        .o_rise  (next_rise)
    );

    // Simultaneous presses are ambiguous, so both are discarded.
    assign prev_evt = prev_rise & ~next_rise;
    assign next_evt = next_rise & ~prev_rise;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        view_idx_d = view_idx_q;

        if (i_valid) begin
            wr_ptr_d   = wr_ptr_q + IDX_W'(1);
            count_d    = (count_q == CNT_FULL) ? count_q : count_q + CNT_W'(1);
            view_idx_d = '0;
            state_d    = S_LIVE;
        end else begin
            case (state_q)
                S_LIVE: begin
                    if (prev_evt && count_q >= CNT_W'(2)) begin
                        view_idx_d = IDX_W'(1);
                        state_d    = S_BROWSE;
                    end
                end
                S_BROWSE: begin
                    // Older steps stop at the oldest stored entry (age count-1).
                    if (prev_evt) begin
                        if (({1'b0, view_idx_q} + CNT_W'(1)) < count_q) begin
                            view_idx_d = view_idx_q + IDX_W'(1);
                        end
                    end else if (next_evt) begin
                        view_idx_d = view_idx_q - IDX_W'(1);
                        if (view_idx_q == IDX_W'(1)) begin
                            state_d = S_LIVE;
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_EMPTY;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            view_idx_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            view_idx_q <= view_idx_d;
            if (i_valid) begin
                mem_q[wr_ptr_q] <= i_data;
            end
        end
    end

    // Newest entry sits just behind the write pointer; the subtraction wraps naturally.
    assign rd_addr     = wr_ptr_q - IDX_W'(1) - view_idx_q;
    assign o_view_data = (state_q == S_EMPTY) ? '0 : mem_q[rd_addr];
    assign o_view_idx  = view_idx_q;
    assign o_count     = count_q;
    assign o_browsing  = (state_q == S_BROWSE);

endmodule

// File: tb/tb_rand_history_viewer.sv
// Directed self-checking bench for rand_history_viewer with hand-computed expected values.
module tb_rand_history_viewer;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_valid;
    logic [3:0] i_data;
    logic       i_prev;
    logic       i_next;
    logic [3:0] o_view_data;
    logic [3:0] o_view_idx;
    logic [4:0] o_count;
    logic       o_browsing;

    int checkCount = 0;
    int errorCount = 0;

    rand_history_viewer dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_prev      (i_prev),
        .i_next      (i_next),
        .o_view_data (o_view_data),
        .o_view_idx  (o_view_idx),
        .o_count     (o_count),
        .o_browsing  (o_browsing)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkView(input string tag, input int data, input int idx, input int cnt, input int br);
        checkOutput({tag, ".data"}, 32'(o_view_data), 32'(data));
        checkOutput({tag, ".idx"}, 32'(o_view_idx), 32'(idx));
        checkOutput({tag, ".count"}, 32'(o_count), 32'(cnt));
        checkOutput({tag, ".browsing"}, 32'(o_browsing), 32'(br));
    endtask

    // Drives one cycle of inputs on a falling edge and returns them to idle on the next falling edge.
    task automatic applyStimulus(input logic v, input logic [3:0] d, input logic p, input logic n);
        @(negedge i_clk);
        i_valid = v;
        i_data  = d;
        i_prev  = p;
        i_next  = n;
        @(negedge i_clk);
        i_valid = 1'b0;
        i_prev  = 1'b0;
        i_next  = 1'b0;
    endtask

    task automatic doReset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
    endtask

    initial begin
        i_rst_n = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        i_prev  = 1'b0;
        i_next  = 1'b0;
        #1 i_rst_n = 1'b0;
        doReset();

        $display("[TB] reset and keys on empty history");
        checkView("reset", 0, 0, 0, 0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        checkView("empty_keys", 0, 0, 0, 0);

        $display("[TB] capture 3,7,9 and browse");
        applyStimulus(1'b1, 4'd3, 1'b0, 1'b0);
        checkView("cap1", 3, 0, 1, 0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        checkView("cap1_prev", 3, 0, 1, 0);
        applyStimulus(1'b1, 4'd7, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd9, 1'b0, 1'b0);
        checkView("cap3", 9, 0, 3, 0);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        checkView("live_next", 9, 0, 3, 0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        checkView("prev1", 7, 1, 3, 1);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        checkView("prev2", 3, 2, 3, 1);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        checkView("prev_sat", 3, 2, 3, 1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        checkView("next1", 7, 1, 3, 1);
        applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        checkView("next2", 9, 0, 3, 0);

        $display("[TB] fill past depth and walk to oldest");
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 4'(k % 16), 1'b0, 1'b0);
        end
        checkView("full", 3, 0, 16, 0);
        for (int k = 0; k < 15; k++) begin
            applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        end
        checkView("oldest", 4, 15, 16, 1);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        checkView("oldest_hold", 4, 15, 16, 1);

        $display("[TB] capture beats key press");
        for (int k = 0; k < 13; k++) begin
            applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
        end
        checkView("idx2", 1, 2, 16, 1);
        applyStimulus(1'b1, 4'd5, 1'b1, 1'b0);
        checkView("valid_wins", 5, 0, 16, 0);

        $display("[TB] simultaneous keys and held key");
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        checkView("to_idx1", 3, 1, 16, 1);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b1);
        checkView("both_keys", 3, 1, 16, 1);
        @(negedge i_clk);
        i_prev = 1'b1;
        repeat (10) @(negedge i_clk);
        i_prev = 1'b0;
        @(negedge i_clk);
        checkView("held_prev", 2, 2, 16, 1);

        $display("[TB] async reset mid-browse");
        doReset();
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b1, 4'(k), 1'b0, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        end
        checkView("pre_reset", 4, 4, 8, 1);
        @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        checkView("async_reset", 0, 0, 0, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        applyStimulus(1'b1, 4'd11, 1'b0, 1'b0);
        checkView("post_reset_cap", 11, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
